ps2_key_ctrl: RTL and testbench

Scan-code sequencer sitting between the PS2 byte receiver and the game logic of the arcade machine. Consumes the receiver's one-cycle `valid`/`code` byte strobes, tracks set-2 make, break (`F0`) and extended (`E0`) prefix sequences, and maintains a held-state vector plus one-cycle press pulses for the six game keys. A timeout counter recovers the sequencer when a prefix is never followed by its key byte.

---
 rtl/ps2_key_if.sv | 25 ++
 rtl/ps2_key_ctrl.sv | 128 ++++++++++++
 tb/tb_ps2_key_ctrl.sv | 234 +++++++++++++++++++++++
 3 files changed

// File: rtl/ps2_key_if.sv
// PS2 key controller bus: receiver byte strobe in, key state out.
// Master side drives bytes (receiver or bench); slave side is the controller.
interface ps2_key_if;
  logic       valid;
  logic [7:0] code;
  logic [5:0] held;
  logic [5:0] press;
  logic       seq_err;

  modport master (
    output valid,
    output code,
    input  held,
    input  press,
    input  seq_err
  );

  modport slave (
    input  valid,
    input  code,
    output held,
    output press,
    output seq_err
  );
endinterface

// File: rtl/ps2_key_ctrl.sv
// Set-2 scan-code sequencer: tracks F0/E0 prefixes, keeps a held vector and
// press pulses for six game keys, and recovers from stalled prefixes.
// Optional macro PS2_REPEAT_FILTER_EN: suppress press pulses for typematic
// repeats of an already-held key.
//
// state   | meaning
// IDLE    | no prefix pending
// BRK     | F0 received
// EXT     | E0 received
// EXT_BRK | E0 F0 received
module ps2_key_ctrl #(
  parameter int TIMEOUT_CYCLES = 100000
) (
  input  logic      clk,
  input  logic      rst,
  ps2_key_if.slave  bus
);

  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);
  localparam logic [CW-1:0] CNT_MAX  = CW'(TIMEOUT_CYCLES);

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] BRK     = 2'd1;
  localparam logic [1:0] EXT     = 2'd2;
  localparam logic [1:0] EXT_BRK = 2'd3;

  logic [1:0]    state_q, state_d;
  logic [5:0]    held_q, held_d;
  logic [5:0]    press_q, press_d;
  logic          err_q, err_d;
  logic [CW-1:0] cnt_q, cnt_d;

  // Extended and plain code spaces are decoded separately so keypad 75/72
  // and extended 44/4B stay unmapped.
  function automatic logic [5:0] key_map(input logic [7:0] c, input logic ext);
    logic [5:0] m;
    m = 6'b000000;
    if (ext) begin
      case (c)
        8'h75:   m = 6'b000100;
        8'h72:   m = 6'b001000;
        default: m = 6'b000000;
      endcase
    end else begin
      case (c)
        8'h1D:   m = 6'b000001;
        8'h1B:   m = 6'b000010;
        8'h44:   m = 6'b000100;
        8'h4B:   m = 6'b001000;
        8'h29:   m = 6'b010000;
        8'h76:   m = 6'b100000;
        default: m = 6'b000000;
      endcase
    end
    return m;
  endfunction

  // Next-state decode: byte handling takes priority over the timeout.
  always_comb begin
    logic [5:0] m;
    logic       is_f0;
    logic       is_e0;
    state_d = state_q;
    held_d  = held_q;
    press_d = 6'b000000;
    err_d   = 1'b0;
    cnt_d   = cnt_q;
    is_f0   = (bus.code == 8'hF0);
    is_e0   = (bus.code == 8'hE0);
    m       = key_map(bus.code, (state_q == EXT) || (state_q == EXT_BRK));

    if (bus.valid) begin
      cnt_d = '0;
      if (is_f0 || is_e0) begin
        // Illegal orders flag an error, then restart as if seen from IDLE.
        if (state_q == EXT && is_f0) begin
          state_d = EXT_BRK;
        end else begin
          err_d   = (state_q != IDLE);
          state_d = is_f0 ? BRK : EXT;
        end
      end else begin
        state_d = IDLE;
        if (state_q == IDLE || state_q == EXT) begin
          held_d = held_q | m;
`ifdef PS2_REPEAT_FILTER_EN
          press_d = m & ~held_q;
`else
          press_d = m;
`endif
        end else begin
          held_d = held_q & ~m;
        end
      end
    end else if (state_q != IDLE) begin
      if (cnt_q == CNT_LAST) begin
        state_d = IDLE;
        err_d   = 1'b1;
        cnt_d   = CNT_MAX;
      end else if (cnt_q != CNT_MAX) begin
        cnt_d = cnt_q + CW'(1);
      end
    end
  end

  // State, key and timeout registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      held_q  <= 6'b000000;
      press_q <= 6'b000000;
      err_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      held_q  <= held_d;
      press_q <= press_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
    end
  end

  assign bus.held    = held_q;
  assign bus.press   = press_q;
  assign bus.seq_err = err_q;

endmodule

// File: tb/tb_ps2_key_ctrl.sv
// Directed bench for ps2_key_ctrl with a short timeout.
module tb_ps2_key_ctrl;
  localparam int TO = 20;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  ps2_key_if bus ();

  ps2_key_ctrl #(.TIMEOUT_CYCLES(TO)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic send_byte(input logic [7:0] b);
    @(posedge clk);
    #1;
    bus.valid = 1'b1;
    bus.code  = b;
    @(posedge clk);
    #1;
    bus.valid = 1'b0;
    bus.code  = 8'h00;
  endtask

  task automatic chk6(input string name, input logic [5:0] act, input logic [5:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %b expected %b", name, act, exp);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %b expected %b", name, act, exp);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #1;
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    #3;
    chk6("reset_held", bus.held, 6'b000000);
    chk6("reset_press", bus.press, 6'b000000);
    chk1("reset_seq_err", bus.seq_err, 1'b0);
    chk1("reset_idle", dut.state_q == 2'd0, 1'b1);
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic test_make();
    send_byte(8'h44);
    chk6("make_held", bus.held, 6'b000100);
    chk6("make_press", bus.press, 6'b000100);
    chk1("make_seq_err", bus.seq_err, 1'b0);
    @(posedge clk);
    #1;
    chk6("make_press_one_cycle", bus.press, 6'b000000);
  endtask

  task automatic test_break();
    send_byte(8'hF0);
    chk6("break_prefix_press", bus.press, 6'b000000);
    send_byte(8'h44);
    chk6("break_held", bus.held, 6'b000000);
    chk6("break_press", bus.press, 6'b000000);
  endtask

  task automatic test_repeat();
    send_byte(8'h44);
    send_byte(8'h44);
`ifdef PS2_REPEAT_FILTER_EN
    chk6("repeat_press", bus.press, 6'b000000);
`else
    chk6("repeat_press", bus.press, 6'b000100);
`endif
    chk6("repeat_held", bus.held, 6'b000100);
    send_byte(8'hF0);
    send_byte(8'h44);
    chk6("repeat_release", bus.held, 6'b000000);
  endtask

  task automatic test_ext();
    send_byte(8'hE0);
    send_byte(8'h75);
    chk6("ext_up_held", bus.held, 6'b000100);
    chk6("ext_up_press", bus.press, 6'b000100);
    send_byte(8'h4B);
    chk6("ext_setup_l", bus.held, 6'b001100);
    send_byte(8'hE0);
    send_byte(8'hF0);
    send_byte(8'h72);
    chk6("ext_down_break", bus.held, 6'b000100);
    chk6("ext_break_press", bus.press, 6'b000000);
    send_byte(8'h7D);
    chk6("unmapped_held", bus.held, 6'b000100);
    chk6("unmapped_press", bus.press, 6'b000000);
    chk1("unmapped_idle", dut.state_q == 2'd0, 1'b1);
    send_byte(8'h72);
    chk6("keypad_72_unmapped", bus.held, 6'b000100);
    send_byte(8'hE0);
    send_byte(8'h44);
    chk6("ext_44_unmapped", bus.held, 6'b000100);
    chk6("ext_44_press", bus.press, 6'b000000);
    send_byte(8'hF0);
    send_byte(8'h44);
    chk6("alias_plain_break", bus.held, 6'b000000);
  endtask

  task automatic test_illegal();
    send_byte(8'h1D);
    chk6("illegal_setup_w", bus.held, 6'b000001);
    send_byte(8'hF0);
    send_byte(8'hF0);
    chk1("illegal_f0_f0_err", bus.seq_err, 1'b1);
    @(posedge clk);
    #1;
    chk1("illegal_err_one_cycle", bus.seq_err, 1'b0);
    send_byte(8'h1D);
    chk6("illegal_reenter_brk", bus.held, 6'b000000);
    send_byte(8'hE0);
    send_byte(8'hE0);
    chk1("illegal_e0_e0_err", bus.seq_err, 1'b1);
    send_byte(8'h75);
    chk6("illegal_reenter_ext", bus.held, 6'b000100);
    send_byte(8'hE0);
    send_byte(8'hF0);
    send_byte(8'hE0);
    chk1("illegal_extbrk_e0_err", bus.seq_err, 1'b1);
    send_byte(8'hF0);
    send_byte(8'h75);
    chk6("illegal_extbrk_recover", bus.held, 6'b000000);
  endtask

  task automatic test_timeout();
    int first;
    int pulses;
    send_byte(8'h76);
    send_byte(8'hF0);
    first  = -1;
    pulses = 0;
    for (int i = 1; i <= TO + 10; i++) begin
      @(posedge clk);
      #1;
      if (bus.seq_err === 1'b1) begin
        pulses++;
        if (first < 0) first = i;
      end
    end
    checks++;
    if (first != TO) begin
      errors++;
      $display("FAIL timeout_cycle got %0d expected %0d", first, TO);
    end
    checks++;
    if (pulses != 1) begin
      errors++;
      $display("FAIL timeout_pulses got %0d expected %0d", pulses, 1);
    end
    chk1("timeout_idle", dut.state_q == 2'd0, 1'b1);
    chk6("timeout_held_kept", bus.held, 6'b100000);
    send_byte(8'h1D);
    chk6("timeout_then_make", bus.held, 6'b100001);
    chk6("timeout_then_press", bus.press, 6'b000001);
  endtask

  task automatic test_timeout_valid_wins();
    send_byte(8'hF0);
    repeat (TO - 2) @(posedge clk);
    send_byte(8'h1D);
    chk1("valid_wins_no_err", bus.seq_err, 1'b0);
    chk6("valid_wins_break", bus.held, 6'b100000);
    @(posedge clk);
    #1;
    chk1("valid_wins_no_late_err", bus.seq_err, 1'b0);
  endtask

  task automatic test_reset_mid();
    do_reset();
    send_byte(8'h29);
    send_byte(8'h76);
    chk6("mid_setup_held", bus.held, 6'b110000);
    send_byte(8'hF0);
    #2;
    rst = 1'b1;
    #1;
    chk6("mid_rst_held", bus.held, 6'b000000);
    chk6("mid_rst_press", bus.press, 6'b000000);
    chk1("mid_rst_err", bus.seq_err, 1'b0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    send_byte(8'h29);
    chk6("mid_after_make", bus.held, 6'b010000);
    chk6("mid_after_press", bus.press, 6'b010000);
  endtask

  initial begin
    checks    = 0;
    errors    = 0;
    rst       = 1'b0;
    bus.valid = 1'b0;
    bus.code  = 8'h00;
    test_reset();
    test_make();
    test_break();
    test_repeat();
    test_ext();
    test_illegal();
    test_timeout();
    test_timeout_valid_wins();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
